// File: rtl/mdu_unit_if.sv
// Command/result bundle between the EX stage and the multiply/divide unit.
// The EX stage drives the command; the MDU returns busy and the HI/LO registers.
interface mdu_unit_if;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, mdu_op, A, B, input busy, HI, LO);
  modport slave  (input start, mdu_op, A, B, output busy, HI, LO);
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
// The result is computed when the command is accepted and released after a fixed latency.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  mdu_unit_if.slave bus
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        shadow_hi_q, shadow_hi_d;
  logic [31:0]        shadow_lo_q, shadow_lo_d;
  logic               wb_en_q, wb_en_d;
  logic               busy_q, busy_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic [63:0] prod_s, prod_u;
  logic        div_signed;
  logic [31:0] div_a, div_b, den, q_mag, r_mag, quo, rem;

  // Products and quotient/remainder from the operands presented this cycle.
  always_comb begin
    prod_s     = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    prod_u     = {32'd0, bus.A} * {32'd0, bus.B};
    div_signed = (bus.mdu_op == OP_DIV);
    div_a      = (div_signed && bus.A[31]) ? (~bus.A + 32'd1) : bus.A;
    div_b      = (div_signed && bus.B[31]) ? (~bus.B + 32'd1) : bus.B;
    // Zero divisor is replaced so the divider stays defined; write-back is suppressed instead.
    den        = (div_b == 32'd0) ? 32'd1 : div_b;
    q_mag      = div_a / den;
    r_mag      = div_a % den;
    quo        = (div_signed && (bus.A[31] ^ bus.B[31])) ? (~q_mag + 32'd1) : q_mag;
    rem        = (div_signed && bus.A[31]) ? (~r_mag + 32'd1) : r_mag;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_hi_d = shadow_hi_q;
    shadow_lo_d = shadow_lo_q;
    wb_en_d     = wb_en_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          unique case (bus.mdu_op)
            OP_MULT, OP_MULTU: begin
              state_d     = RUN;
              cnt_d       = CNT_W'(MULT_CYCLES);
              {shadow_hi_d, shadow_lo_d} = (bus.mdu_op == OP_MULT) ? prod_s : prod_u;
              wb_en_d     = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              state_d     = RUN;
              cnt_d       = CNT_W'(DIV_CYCLES);
              shadow_hi_d = rem;
              shadow_lo_d = quo;
              wb_en_d     = (bus.B != 32'd0);
            end
            OP_MTHI: hi_d = bus.A;
            OP_MTLO: lo_d = bus.A;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          if (wb_en_q) begin
            hi_d = shadow_hi_q;
            lo_d = shadow_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shadow_hi_q <= '0;
      shadow_lo_q <= '0;
      wb_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_hi_q <= shadow_hi_d;
      shadow_lo_q <= shadow_lo_d;
      wb_en_q     <= wb_en_d;
      busy_q      <= busy_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed scenarios plus random commands
// checked against an arithmetic model of HI/LO and the expected busy length.
module tb_mdu_unit;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_unit_if bus();

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          asserts = 0;
  int          fails   = 0;
  logic [31:0] exp_hi  = 32'd0;
  logic [31:0] exp_lo  = 32'd0;

  // Architectural effect of one accepted command on HI/LO.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = 64'(sa * sb); exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'd2: if (b != 32'd0) begin
        q = sa / sb; r = sa % sb;
        exp_lo = 32'(q); exp_hi = 32'(r);
      end
      3'd3: if (b != 32'd0) begin exp_lo = a / b; exp_hi = a % b; end
      3'd4: exp_hi = a;
      3'd5: exp_lo = a;
      default: ;
    endcase
  endfunction

  function automatic int exp_cycles(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return int'(MC);
      3'd2, 3'd3: return int'(DC);
      default:    return 0;
    endcase
  endfunction

  // Present one command for one edge, then scramble the operands.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mdu_op = op;
    bus.A      = a;
    bus.B      = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) n++;
      else break;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    int en;
    en = exp_cycles(op);
    model(op, a, b);
    issue(op, a, b);
    wait_idle(n);
    asserts++;
    if (n !== en) begin
      fails++;
      $display("FAIL %s busy_cycles got %0d expected %0d", name, n, en);
    end
    asserts++;
    if (bus.HI !== exp_hi || bus.LO !== exp_lo) begin
      fails++;
      $display("FAIL %s hilo got %h_%h expected %h_%h", name, bus.HI, bus.LO, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.mdu_op = 3'd0;
    bus.A      = 32'd0;
    bus.B      = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    asserts++;
    if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      fails++;
      $display("FAIL reset got busy=%b hi=%h lo=%h expected 0/0/0", bus.busy, bus.HI, bus.LO);
    end
    reset = 1'b0;
    run_op("mtlo", 3'd5, 32'h1234_5678, 32'd0);
    asserts++;
    if (bus.LO !== 32'h1234_5678) begin
      fails++;
      $display("FAIL mtlo_const got %h expected 12345678", bus.LO);
    end
  endtask

  task automatic test_mult;
    run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3);
    asserts++;
    if (bus.HI !== 32'hFFFF_FFFF || bus.LO !== 32'hFFFF_FFFA) begin
      fails++;
      $display("FAIL mult_const got %h_%h expected ffffffff_fffffffa", bus.HI, bus.LO);
    end
    run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3);
    asserts++;
    if (bus.HI !== 32'h0000_0002 || bus.LO !== 32'hFFFF_FFFA) begin
      fails++;
      $display("FAIL multu_const got %h_%h expected 00000002_fffffffa", bus.HI, bus.LO);
    end
  endtask

  task automatic test_div;
    run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2);
    asserts++;
    if (bus.HI !== 32'hFFFF_FFFF || bus.LO !== 32'hFFFF_FFFD) begin
      fails++;
      $display("FAIL div_const got %h_%h expected ffffffff_fffffffd", bus.HI, bus.LO);
    end
    run_op("divu", 3'd3, 32'd7, 32'd2);
    asserts++;
    if (bus.HI !== 32'd1 || bus.LO !== 32'd3) begin
      fails++;
      $display("FAIL divu_const got %h_%h expected 00000001_00000003", bus.HI, bus.LO);
    end
  endtask

  task automatic test_div_corner;
    run_op("mthi", 3'd4, 32'hAAAA_0000, 32'd0);
    run_op("mtlo2", 3'd5, 32'h0000_5555, 32'd0);
    run_op("div_by_zero", 3'd2, 32'd1234, 32'd0);
    asserts++;
    if (bus.HI !== 32'hAAAA_0000 || bus.LO !== 32'h0000_5555) begin
      fails++;
      $display("FAIL div0_const got %h_%h expected aaaa0000_00005555", bus.HI, bus.LO);
    end
    run_op("divu_by_zero", 3'd3, 32'd99, 32'd0);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    asserts++;
    if (bus.HI !== 32'd0 || bus.LO !== 32'h8000_0000) begin
      fails++;
      $display("FAIL div_ovf_const got %h_%h expected 00000000_80000000", bus.HI, bus.LO);
    end
  endtask

  task automatic test_start_while_busy;
    int n;
    model(3'd0, 32'h0001_2345, 32'hFFFF_0007);
    issue(3'd0, 32'h0001_2345, 32'hFFFF_0007);
    @(negedge clk);
    asserts++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_c1 got %b expected 1", bus.busy);
    end
    bus.start  = 1'b1;
    bus.mdu_op = 3'd4;
    bus.A      = 32'h0000_DEAD;
    @(posedge clk);
    #1;
    bus.mdu_op = 3'd3;
    bus.A      = 32'd100;
    bus.B      = 32'd7;
    @(negedge clk);
    asserts++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_c2 got %b expected 1", bus.busy);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
    wait_idle(n);
    asserts++;
    if (n + 2 !== int'(MC)) begin
      fails++;
      $display("FAIL ignore_busy_cycles got %0d expected %0d", n + 2, MC);
    end
    asserts++;
    if (bus.HI !== exp_hi || bus.LO !== exp_lo) begin
      fails++;
      $display("FAIL ignore_hilo got %h_%h expected %h_%h", bus.HI, bus.LO, exp_hi, exp_lo);
    end
    // Confirm nothing was queued behind the ignored commands.
    @(negedge clk);
    asserts++;
    if (bus.busy !== 1'b0 || bus.HI !== exp_hi || bus.LO !== exp_lo) begin
      fails++;
      $display("FAIL ignore_after got busy=%b %h_%h expected 0 %h_%h", bus.busy, bus.HI, bus.LO, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset_abort;
    logic bad;
    issue(3'd2, 32'h0000_0100, 32'd3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    @(negedge clk);
    asserts++;
    if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      fails++;
      $display("FAIL abort got busy=%b hi=%h lo=%h expected 0/0/0", bus.busy, bus.HI, bus.LO);
    end
    bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) bad = 1'b1;
    end
    asserts++;
    if (bad !== 1'b0) begin
      fails++;
      $display("FAIL abort_late_wb got busy=%b hi=%h lo=%h expected 0/0/0", bus.busy, bus.HI, bus.LO);
    end
  endtask

  task automatic test_random;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 9));
        2:       b = -32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      run_op("random", op, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_corner();
    test_start_while_busy();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
